uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (8N1) with a one-byte holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose parity_err.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             rx_in,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_ONE  = OS_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_r;
    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] tick_cnt_r;
    logic             tick_s;
    logic [OS_W-1:0]  os_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic             frame_err_r;
    logic             overrun_err_r;
    logic             busy_r;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_r;
    logic             parity_err_r;

    function automatic logic even_parity(input logic [7:0] data);
        even_parity = ^data;
    endfunction

    assign parity_err = parity_err_r;
`endif

    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign frame_err   = frame_err_r;
    assign overrun_err = overrun_err_r;
    assign busy        = busy_r;
    assign tick_s      = (tick_cnt_r == div_r);

    // Two-flop synchronizer plus a history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Oversample tick divider; parked at zero in IDLE so each frame starts phase-aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= {DIV_W{1'b0}};
        end else if (state_r == IDLE || tick_s) begin
            tick_cnt_r <= {DIV_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + DIV_ONE;
        end
    end

    // Frame FSM: bit timing, shifting, holding register and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            div_r         <= {DIV_W{1'b0}};
            os_cnt_r      <= {OS_W{1'b0}};
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            rx_data_r     <= 8'h00;
            rx_valid_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
            busy_r        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_r     <= 1'b0;
            parity_err_r  <= 1'b0;
`endif
        end else begin
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r  <= 1'b0;
`endif
            // A load later in this block overrides the consume-clear
            if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r   <= START;
                        div_r     <= baud_div;
                        os_cnt_r  <= {OS_W{1'b0}};
                        bit_cnt_r <= 3'd0;
                        busy_r    <= 1'b1;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (os_cnt_r == OS_HALF) begin
                            os_cnt_r <= {OS_W{1'b0}};
                            if (!rx_sync_r) begin
                                state_r <= DATA;
                            end else begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_ONE;
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (os_cnt_r == OS_LAST) begin
                            os_cnt_r  <= {OS_W{1'b0}};
                            shift_r   <= {rx_sync_r, shift_r[7:1]};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_r <= PARITY;
`else
                                state_r <= STOP;
`endif
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_ONE;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_s) begin
                        if (os_cnt_r == OS_LAST) begin
                            os_cnt_r  <= {OS_W{1'b0}};
                            par_bit_r <= rx_sync_r;
                            state_r   <= STOP;
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_ONE;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick_s) begin
                        if (os_cnt_r == OS_LAST) begin
                            os_cnt_r <= {OS_W{1'b0}};
                            state_r  <= IDLE;
                            busy_r   <= 1'b0;
                            if (!rx_sync_r) begin
                                frame_err_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bit_r != even_parity(shift_r)) begin
                                parity_err_r <= 1'b1;
`endif
                            end else if (!rx_valid_r || rx_ready) begin
                                rx_data_r  <= shift_r;
                                rx_valid_r <= 1'b1;
                            end else begin
                                overrun_err_r <= 1'b1;
                            end
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level event model compared every cycle plus literal checks.
module tb_uart_rx;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Edge (after line drop) at which the stop bit is judged: sync+detect, half bit, full bits
    localparam int STOP_LAT = 3 + OS / 2 + OS * (9 + NPAR);

    typedef struct {
        int         at;
        logic [7:0] data;
        bit         stop_ok;
        bit         par_ok;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        rx_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun_err;
    logic        busy;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
    logic        exp_perr;
    int          perr_n = 0;
    int          p0;
`endif

    ev_t         evq[$];
    logic [7:0]  exp_data;
    logic        exp_valid;
    logic        exp_ferr;
    logic        exp_oerr;
    int          cyc = 0;
    int          bs = 0;
    int          be = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_on = 1'b0;
    int          valid_n = 0;
    int          ferr_n = 0;
    int          oerr_n = 0;
    int          busy_n = 0;
    logic [7:0]  last_data = 8'h00;
    int          v0, f0, o0, b0;
    logic [7:0]  pats [4] = '{8'h00, 8'hFF, 8'h01, 8'h80};

    uart_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_div    (baud_div),
        .rx_in       (rx_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-level model: the holding register reacts only at each frame's stop-sample edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid <= 1'b0;
            exp_data  <= 8'h00;
            exp_ferr  <= 1'b0;
            exp_oerr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            exp_perr  <= 1'b0;
`endif
            evq.delete();
        end else begin
            exp_ferr <= 1'b0;
            exp_oerr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            exp_perr <= 1'b0;
`endif
            if (exp_valid && rx_ready) exp_valid <= 1'b0;
            if (evq.size() != 0 && evq[0].at == cyc + 1) begin
                if (!evq[0].stop_ok) exp_ferr <= 1'b1;
`ifdef UART_RX_PARITY_EN
                else if (!evq[0].par_ok) exp_perr <= 1'b1;
`endif
                else if (!exp_valid || rx_ready) begin
                    exp_data  <= evq[0].data;
                    exp_valid <= 1'b1;
                end else exp_oerr <= 1'b1;
                evq.pop_front();
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("valid", int'(rx_valid), int'(exp_valid));
            check("data", int'(rx_data), int'(exp_data));
            check("frame_err", int'(frame_err), int'(exp_ferr));
            check("overrun_err", int'(overrun_err), int'(exp_oerr));
            check("busy", int'(busy), int'(rst_n && cyc >= bs && cyc < be));
`ifdef UART_RX_PARITY_EN
            check("parity_err", int'(parity_err), int'(exp_perr));
`endif
        end
    end

    // Running event counters for the literal checks
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_n   <= valid_n + 1;
            last_data <= rx_data;
        end
        if (frame_err) ferr_n <= ferr_n + 1;
        if (overrun_err) oerr_n <= oerr_n + 1;
        if (busy) busy_n <= busy_n + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_n <= perr_n + 1;
`endif
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        idle(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        ev_t ev;
        idle(1);
        ev.at      = cyc + STOP_LAT;
        ev.data    = d;
        ev.stop_ok = stop_bit;
        ev.par_ok  = !par_flip;
        bs = cyc + 3;
        be = cyc + STOP_LAT;
        evq.push_back(ev);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic snap();
        v0 = valid_n;
        f0 = ferr_n;
        o0 = oerr_n;
        b0 = busy_n;
`ifdef UART_RX_PARITY_EN
        p0 = perr_n;
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d3c;
        rst_n    = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b1;
        baud_div = 16'd0;
        idle(3);
        chk_on = 1'b1;
        check("rst_data", int'(rx_data), 32'h00);
        check("rst_valid", int'(rx_valid), 32'd0);
        check("rst_busy", int'(busy), 32'd0);
        check("rst_ferr", int'(frame_err), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // 0xA5 with the divisor disturbed mid-frame
        snap();
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                idle(40);
                baud_div = 16'd7;
            end
        join
        baud_div = 16'd0;
        idle(10);
        check("a5_valid_cycles", valid_n - v0, 1);
        check("a5_data", int'(last_data), 32'hA5);
        check("a5_errs", (ferr_n - f0) + (oerr_n - o0), 0);

        foreach (pats[i]) begin
            send_frame(pats[i], 1'b1, 1'b0);
            idle(5);
            check("pat_data", int'(last_data), int'(pats[i]));
        end

        // False start: 4 low cycles, busy for exactly half a bit
        snap();
        idle(1);
        bs = cyc + 3;
        be = cyc + 3 + OS / 2;
        rx_in = 1'b0;
        idle(4);
        rx_in = 1'b1;
        idle(30);
        check("false_busy_cycles", busy_n - b0, 8);
        check("false_valid", valid_n - v0, 0);
        check("false_ferr", ferr_n - f0, 0);

        // 0x5A with bad stop bit, then line held low as a break
        snap();
        send_frame(8'h5A, 1'b0, 1'b0);
        check("break_ferr", ferr_n - f0, 1);
        check("break_valid", valid_n - v0, 0);
        b0 = busy_n;
        idle(200);
        check("break_busy", busy_n - b0, 0);
        rx_in = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(5);
        check("after_break_data", int'(last_data), 32'h81);

        // Overrun: consumer stalled across two frames
        snap();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        idle(5);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(5);
        check("ovr_data", int'(rx_data), 32'h11);
        check("ovr_valid", int'(rx_valid), 32'd1);
        check("ovr_pulses", oerr_n - o0, 1);
        rx_ready = 1'b1;
        idle(2);
        check("ovr_drained", int'(rx_valid), 32'd0);

        // Reset during data bit 3 of 0x3C, then a clean 0x3C
        d3c = 8'h3C;
        idle(1);
        bs = cyc + 3;
        be = cyc + 100000;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d3c[i]);
        rx_in = d3c[3];
        idle(8);
        be = cyc;
        rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        check("mid_rst_data", int'(rx_data), 32'h00);
        check("mid_rst_busy", int'(busy), 32'd0);
        idle(4);
        rst_n = 1'b1;
        idle(10);
        snap();
        send_frame(d3c, 1'b1, 1'b0);
        idle(5);
        check("post_rst_data", int'(last_data), 32'h3C);
        check("post_rst_valid", valid_n - v0, 1);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        check("par_bad_pulse", perr_n - p0, 1);
        check("par_bad_valid", valid_n - v0, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(5);
        check("par_good_data", int'(last_data), 32'h07);
        check("par_good_pulse", perr_n - p0, 1);
`endif

        idle(5);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
